// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sequencer sharing one fixed-latency memory between fetch and data ports
// Every memory-side and requester-side output is a register written by the single FSM block.

module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} port_t;

  state_t           state;
  port_t            owner;
  port_t            last;
  logic             is_write;
  logic [CNT_W-1:0] cnt;

  logic grant_d;
  logic grant_store;

  // On a tie the data port wins only if fetch was served last.
  always_comb begin
    grant_d     = d_req & (~if_req | (last == OWN_IF));
    grant_store = grant_d & d_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      last      <= OWN_D;
      is_write  <= 1'b0;
      cnt       <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req | d_req) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            owner    <= grant_d ? OWN_D : OWN_IF;
            last     <= grant_d ? OWN_D : OWN_IF;
            is_write <= grant_store;
            mem_addr <= grant_d ? d_addr : if_addr;
            if (grant_store) begin
              mem_wdata <= d_wdata;
            end
            // Strobes are launched here so they are high exactly during ISSUE.
            mem_re <= ~grant_store;
            mem_we <= grant_store;
          end
        end
        ISSUE: begin
          if (is_write) begin
            state <= RESP;
            if (owner == OWN_D) d_done <= 1'b1;
            else                if_done <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= CNT_W'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= RESP;
            if (owner == OWN_D) begin
              d_rdata <= mem_rdata;
              d_done  <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Transaction-level monitor plus directed table, corner sequences and random traffic.

module tb_mem_port_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [63:0] if_addr, d_addr, d_wdata;
  logic [63:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, d_done, mem_re, mem_we, busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(L), .ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] fill(input logic [63:0] a);
    return {a[31:0] ^ 32'h1357_9bdf, ~a[31:0]};
  endfunction

  // Memory environment: a read returns data only in cycle ISSUE+L; other cycles carry junk.
  logic [63:0] env_mem [logic [63:0]];
  logic [63:0] pipe [L];
  logic [63:0] env_v;
  assign mem_rdata = pipe[L-1];

  always @(posedge clk) begin
    if (mem_we) env_mem[mem_addr] = mem_wdata;
    env_v = env_mem.exists(mem_addr) ? env_mem[mem_addr] : fill(mem_addr);
    pipe[0] <= mem_re ? env_v : {$urandom, $urandom};
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end

  // Reference model: serialised transactions with round-robin ties and fixed response timing.
  logic [63:0] ref_mem [logic [63:0]];
  bit          mon_on = 0;
  bit          act = 0, t_owner, t_wr, prev_win = 1, pend = 0;
  int          t_done, last_strobe_cyc = 0;
  logic [63:0] t_data, if_hold = '0, d_hold = '0;
  bit          r_if, r_d, r_we, win, exp_if_done, exp_d_done, strobe;
  logic [63:0] r_ia, r_da, r_wd;

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      strobe = mem_re | mem_we;
      chk1("strobe_timing", strobe, pend);
      if (strobe) last_strobe_cyc = cyc;
      if (pend && strobe) begin
        win = (r_if && r_d) ? ~prev_win : r_d;
        prev_win = win;
        chk64("mem_addr", mem_addr, win ? r_da : r_ia);
        chk1("mem_we", mem_we, win & r_we);
        chk1("mem_re", mem_re, ~(win & r_we));
        act     = 1;
        t_owner = win;
        t_wr    = win & r_we;
        t_done  = cyc + (t_wr ? 1 : 1 + L);
        t_data  = t_wr ? 64'h0 : ref_rd(win ? r_da : r_ia);
        if (t_wr) begin
          chk64("mem_wdata", mem_wdata, r_wd);
          ref_mem[r_da] = r_wd;
        end
      end
      chk1("busy", busy, act && cyc <= t_done);
      exp_if_done = act && cyc == t_done && !t_owner;
      exp_d_done  = act && cyc == t_done && t_owner;
      chk1("if_done", if_done, exp_if_done);
      chk1("d_done", d_done, exp_d_done);
      if (exp_if_done && !t_wr) if_hold = t_data;
      if (exp_d_done && !t_wr) d_hold = t_data;
      chk64("if_rdata", if_rdata, if_hold);
      chk64("d_rdata", d_rdata, d_hold);
      pend = !(act && cyc <= t_done) && !rst && (if_req || d_req);
      r_if = if_req; r_d = d_req; r_we = d_we;
      r_ia = if_addr; r_da = d_addr; r_wd = d_wdata;
      if (rst) begin
        act = 0; prev_win = 1; pend = 0; if_hold = '0; d_hold = '0;
      end
    end
  end

  // Extra builds with MEM_LAT = 1 and 5, fetch-only.
  logic        x_req [2];
  logic [63:0] x_addr [2], x_rdata [2], x_drdata [2], x_maddr [2], x_wdata [2], x_mrdata [2];
  logic        x_done [2], x_ddone [2], x_re [2], x_we [2], x_busy [2];

  for (genvar g = 0; g < 2; g++) begin : lat_g
    localparam int LX = (g == 0) ? 1 : 5;
    logic [63:0] p [LX];
    assign x_mrdata[g] = p[LX-1];
    always @(posedge clk) begin
      p[0] <= x_re[g] ? fill(x_maddr[g]) : {$urandom, $urandom};
      for (int i = 1; i < LX; i++) p[i] <= p[i-1];
    end
    mem_port_arbiter #(.MEM_LAT(LX), .ADDR_W(64), .DATA_W(64)) u_x (
      .clk(clk), .rst(rst),
      .if_req(x_req[g]), .if_addr(x_addr[g]), .if_rdata(x_rdata[g]), .if_done(x_done[g]),
      .d_req(1'b0), .d_we(1'b0), .d_addr(64'h0), .d_wdata(64'h0),
      .d_rdata(x_drdata[g]), .d_done(x_ddone[g]),
      .mem_addr(x_maddr[g]), .mem_re(x_re[g]), .mem_we(x_we[g]), .mem_wdata(x_wdata[g]),
      .mem_rdata(x_mrdata[g]), .busy(x_busy[g])
    );
  end

  // Drives one request from the current cycle until its done; called at posedge+1.
  task automatic do_one(input bit port, input bit we, input logic [63:0] a, input logic [63:0] wd,
                        input bit hold, output int lat, output logic [63:0] rd);
    int t0;
    bit got;
    got = 0; lat = -1; rd = '0;
    if (port) begin
      d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      if_req = 1; if_addr = a;
    end
    t0 = cyc;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk); #1;
      if (port ? d_done : if_done) begin
        got = 1;
        lat = cyc - t0;
        rd  = port ? d_rdata : if_rdata;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout port=%0d actual=none required=done", port);
    end
    if (!hold) begin
      if (port) d_req = 0; else if_req = 0;
    end
  endtask

  task automatic fetch_x(input int g, input logic [63:0] a, input int exp_lat);
    int t0, lat;
    lat = -1;
    x_req[g] = 1; x_addr[g] = a;
    t0 = cyc;
    for (int i = 0; i < 30 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (x_done[g]) begin
        lat = cyc - t0;
        chk64($sformatf("lat%0d_rdata", g), x_rdata[g], fill(a));
      end
    end
    x_req[g] = 0;
    chk64($sformatf("lat%0d_done_cycle", g), 64'(lat), 64'(exp_lat));
  endtask

  task automatic drv(input bit port, input int n);
    bit          we, hold;
    logic [63:0] a, wd, rd;
    int          lat;
    for (int k = 0; k < n; k++) begin
      we   = port && ($urandom_range(0, 1) == 1);
      a    = 64'($urandom_range(0, 15)) << 3;
      wd   = {$urandom, $urandom};
      hold = ($urandom_range(0, 3) == 0) && (k < n - 1);
      do_one(port, we, a, wd, hold, lat, rd);
      if (!hold) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          lat;
    logic [63:0] rdata;
  } vec_t;

  vec_t        tbl [6];
  int          lat, t_first;
  logic [63:0] rd;
  bit          order [$];

  initial begin
    tbl[0] = '{0, 0, 64'h40, 64'h0,    2 + L, 64'hD280_0001_F800_0000};
    tbl[1] = '{1, 1, 64'h08, 64'h1234, 2,     64'h0};
    tbl[2] = '{1, 0, 64'h08, 64'h0,    2 + L, 64'h1234};
    tbl[3] = '{0, 0, 64'h08, 64'h0,    2 + L, 64'h1234};
    tbl[4] = '{1, 1, 64'h10, 64'hCAFE, 2,     64'h0};
    tbl[5] = '{1, 0, 64'h10, 64'h0,    2 + L, 64'hCAFE};

    env_mem[64'h40] = 64'hD280_0001_F800_0000;
    ref_mem[64'h40] = 64'hD280_0001_F800_0000;
    if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0;
    for (int g = 0; g < 2; g++) begin x_req[g] = 0; x_addr[g] = '0; end
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    mon_on = 1;
    chk1("reset_busy", busy, 1'b0);
    chk64("reset_mem_addr", mem_addr, 64'h0);
    chk64("reset_if_rdata", if_rdata, 64'h0);

    for (int i = 0; i < 6; i++) begin
      do_one(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, 0, lat, rd);
      chk64($sformatf("tbl%0d_done_cycle", i), 64'(lat), 64'(tbl[i].lat));
      if (!tbl[i].we) chk64($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
      @(posedge clk); #1;
    end

    // Back-to-back fetches: second ISSUE two cycles after first done.
    do_one(0, 0, 64'h0, 64'h0, 1, lat, rd);
    chk64("b2b_first_data", rd, fill(64'h0));
    t_first = cyc;
    do_one(0, 0, 64'h4, 64'h0, 0, lat, rd);
    chk64("b2b_second_data", rd, fill(64'h4));
    chk64("b2b_issue_gap", 64'(last_strobe_cyc - t_first), 64'd2);
    @(posedge clk); #1;

    // Reset during WAIT abandons the load.
    d_req = 1; d_we = 0; d_addr = 64'h10;
    repeat (2) begin @(posedge clk); #1; end
    chk1("abort_busy_in_wait", busy, 1'b1);
    rst = 1; d_req = 0;
    @(posedge clk); #1;
    rst = 0;
    chk1("abort_mem_re", mem_re, 1'b0);
    chk1("abort_mem_we", mem_we, 1'b0);
    chk64("abort_mem_addr", mem_addr, 64'h0);
    chk64("abort_mem_wdata", mem_wdata, 64'h0);
    chk64("abort_if_rdata", if_rdata, 64'h0);
    chk64("abort_d_rdata", d_rdata, 64'h0);
    chk1("abort_busy", busy, 1'b0);
    repeat (6) begin
      chk1("abort_no_done", d_done | if_done, 1'b0);
      @(posedge clk); #1;
    end
    do_one(1, 0, 64'h10, 64'h0, 0, lat, rd);
    chk64("after_abort_lat", 64'(lat), 64'(2 + L));
    chk64("after_abort_data", rd, 64'hCAFE);

    // Both ports held for three accesses each after reset: strict alternation from IF.
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    fork
      begin
        int          l0;
        logic [63:0] r0;
        for (int k = 0; k < 3; k++) begin
          do_one(0, 0, 64'h100 + 64'(k * 8), 64'h0, k < 2, l0, r0);
          order.push_back(1'b0);
          chk64("simul_if_data", r0, fill(64'h100 + 64'(k * 8)));
        end
      end
      begin
        int          l1;
        logic [63:0] r1;
        for (int k = 0; k < 3; k++) begin
          do_one(1, 0, 64'h200 + 64'(k * 8), 64'h0, k < 2, l1, r1);
          order.push_back(1'b1);
          chk64("simul_d_data", r1, fill(64'h200 + 64'(k * 8)));
        end
      end
    join
    chk64("simul_count", 64'(order.size()), 64'd6);
    for (int i = 0; i < order.size(); i++)
      chk1($sformatf("grant_order%0d", i), order[i], (i % 2) == 1);
    @(posedge clk); #1;

    fetch_x(0, 64'h18, 3);
    fetch_x(1, 64'h20, 7);
    fetch_x(0, 64'h28, 3);
    fetch_x(1, 64'h30, 7);

    fork
      drv(0, 40);
      drv(1, 40);
    join
    repeat (10) begin @(posedge clk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
